// File: rtl/cva6_l1_tlb_plru.sv
// Fully-associative L1 TLB with tree-PLRU replacement and selective flush.
// Optional hit/miss counters are enabled by defining CVA6_TLB_PERF_CNT_EN.
module cva6_l1_tlb_plru #(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned ASID_WIDTH  = 16,
  parameter int unsigned LEVELS      = 3,
  parameter int unsigned PPN_WIDTH   = 44
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   flush_asid_en_i,
  input  logic                   flush_vpn_en_i,
  input  logic [ASID_WIDTH-1:0]  flush_asid_i,
  input  logic [9*LEVELS-1:0]    flush_vpn_i,
  input  logic                   update_valid_i,
  input  logic [9*LEVELS-1:0]    update_vpn_i,
  input  logic [ASID_WIDTH-1:0]  update_asid_i,
  input  logic [1:0]             update_level_i,
  input  logic [PPN_WIDTH-1:0]   update_ppn_i,
  input  logic [7:0]             update_flags_i,
  input  logic                   lu_valid_i,
  input  logic [9*LEVELS-1:0]    lu_vpn_i,
  input  logic [ASID_WIDTH-1:0]  lu_asid_i,
  output logic                   lu_valid_o,
  output logic                   lu_hit_o,
  output logic [PPN_WIDTH-1:0]   lu_ppn_o,
  output logic [7:0]             lu_flags_o,
  output logic [1:0]             lu_level_o
`ifdef CVA6_TLB_PERF_CNT_EN
  ,
  output logic [31:0]            hit_cnt_o,
  output logic [31:0]            miss_cnt_o
`endif
);

  localparam int unsigned VPN_W  = 9 * LEVELS;
  localparam int unsigned IDX_W  = $clog2(TLB_ENTRIES);
  localparam int unsigned TREE_W = TLB_ENTRIES - 1;

  typedef struct packed {
    logic [VPN_W-1:0]      vpn;
    logic [ASID_WIDTH-1:0] asid;
    logic [1:0]            level;
    logic [PPN_WIDTH-1:0]  ppn;
    logic [7:0]            flags;
  } entry_t;

  entry_t                 tag_q [TLB_ENTRIES];
  entry_t                 tag_d [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] valid_q, valid_d;
  logic [TREE_W-1:0]      plru_q, plru_d;

  logic                   lu_valid_q, lu_valid_d;
  logic                   lu_hit_q, lu_hit_d;
  logic [PPN_WIDTH-1:0]   lu_ppn_q, lu_ppn_d;
  logic [7:0]             lu_flags_q, lu_flags_d;
  logic [1:0]             lu_level_q, lu_level_d;

  logic [TLB_ENTRIES-1:0] kill;
  logic [TLB_ENTRIES-1:0] valid_fl;
  logic                   hit, hit_eff;
  logic [IDX_W-1:0]       hit_idx;
  logic                   same_found, inv_found;
  logic [IDX_W-1:0]       same_idx, inv_idx, victim, upd_idx;
  logic                   upd_en;
  logic [PPN_WIDTH-1:0]   pmask, vext, ppn_eff;

  // Bits at and above the given page level take part in the tag compare
  function automatic logic [VPN_W-1:0] vmask(input logic [1:0] lvl);
    logic [VPN_W-1:0] m;
    m = '1;
    return m << (9 * lvl);
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right)
  function automatic logic [TREE_W-1:0] touch(
    input logic [TREE_W-1:0] t,
    input logic [IDX_W-1:0]  e
  );
    logic [TREE_W-1:0] r;
    logic [IDX_W-1:0]  n;
    r = t;
    n = '0;
    for (int l = 0; l < IDX_W; l++) begin
      r[n] = ~e[IDX_W-1-l];
      n = (n << 1) + IDX_W'(1) + IDX_W'(e[IDX_W-1-l]);
    end
    return r;
  endfunction

  always_comb begin
    victim = '0;
    begin
      logic [IDX_W-1:0] n;
      n = '0;
      for (int l = 0; l < IDX_W; l++) begin
        victim = (victim << 1) | IDX_W'(plru_q[n]);
        n = (n << 1) + IDX_W'(1) + IDX_W'(plru_q[n]);
      end
    end
  end

  always_comb begin
    kill       = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    same_found = 1'b0;
    same_idx   = '0;
    inv_found  = 1'b0;
    inv_idx    = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      kill[i] = flush_i
        && (!flush_asid_en_i
            || (!tag_q[i].flags[5] && tag_q[i].asid == flush_asid_i))
        && (!flush_vpn_en_i
            || ((tag_q[i].vpn ^ flush_vpn_i)
                & vmask(tag_q[i].level)) == '0);
    end
    valid_fl = valid_q & ~kill;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i]
          && (tag_q[i].flags[5] || tag_q[i].asid == lu_asid_i)
          && ((tag_q[i].vpn ^ lu_vpn_i)
              & vmask(tag_q[i].level)) == '0) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (valid_fl[i]
          && tag_q[i].asid == update_asid_i
          && tag_q[i].level == update_level_i
          && ((tag_q[i].vpn ^ update_vpn_i)
              & vmask(update_level_i)) == '0) begin
        same_found = 1'b1;
        same_idx   = IDX_W'(i);
      end
      if (!valid_fl[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
  end

  assign upd_en  = update_valid_i & update_flags_i[0];
  assign upd_idx = same_found ? same_idx
                 : inv_found  ? inv_idx
                 : victim;
  assign hit_eff = lu_valid_i & hit & ~flush_i;

  always_comb begin
    pmask   = '1;
    pmask   = pmask << (9 * tag_q[hit_idx].level);
    vext    = PPN_WIDTH'(lu_vpn_i);
    ppn_eff = (tag_q[hit_idx].ppn & pmask) | (vext & ~pmask);
  end

  always_comb begin
    valid_d = valid_fl;
    tag_d   = tag_q;
    if (upd_en) begin
      valid_d[upd_idx]       = 1'b1;
      tag_d[upd_idx].vpn     = update_vpn_i;
      tag_d[upd_idx].asid    = update_asid_i;
      tag_d[upd_idx].level   = update_level_i;
      tag_d[upd_idx].ppn     = update_ppn_i;
      tag_d[upd_idx].flags   = update_flags_i;
    end
    plru_d = plru_q;
    if (hit_eff) plru_d = touch(plru_d, hit_idx);
    if (upd_en)  plru_d = touch(plru_d, upd_idx);
  end

  always_comb begin
    lu_valid_d = lu_valid_i;
    lu_hit_d   = lu_hit_q;
    lu_ppn_d   = lu_ppn_q;
    lu_flags_d = lu_flags_q;
    lu_level_d = lu_level_q;
    if (lu_valid_i) begin
      lu_hit_d   = hit_eff;
      lu_ppn_d   = hit_eff ? ppn_eff : '0;
      lu_flags_d = hit_eff ? tag_q[hit_idx].flags : '0;
      lu_level_d = hit_eff ? tag_q[hit_idx].level : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      plru_q     <= '0;
      lu_valid_q <= 1'b0;
      lu_hit_q   <= 1'b0;
      lu_ppn_q   <= '0;
      lu_flags_q <= '0;
      lu_level_q <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) tag_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      plru_q     <= plru_d;
      lu_valid_q <= lu_valid_d;
      lu_hit_q   <= lu_hit_d;
      lu_ppn_q   <= lu_ppn_d;
      lu_flags_q <= lu_flags_d;
      lu_level_q <= lu_level_d;
      for (int i = 0; i < TLB_ENTRIES; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign lu_valid_o = lu_valid_q;
  assign lu_hit_o   = lu_hit_q;
  assign lu_ppn_o   = lu_ppn_q;
  assign lu_flags_o = lu_flags_q;
  assign lu_level_o = lu_level_q;

`ifdef CVA6_TLB_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        full_flush;

  assign full_flush = flush_i & ~flush_asid_en_i & ~flush_vpn_en_i;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (full_flush) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (lu_valid_i) begin
      if (hit_eff && hit_cnt_q != '1)
        hit_cnt_d = hit_cnt_q + 32'd1;
      if (!hit_eff && miss_cnt_q != '1)
        miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cva6_l1_tlb_plru.sv
// Directed bench for cva6_l1_tlb_plru: vector table plus hand sequences.
// Define CVA6_TLB_PERF_CNT_EN to also exercise the counters.
module tb_cva6_l1_tlb_plru;

  logic        clk;
  logic        rst_n;
  logic        flush, flush_asid_en, flush_vpn_en;
  logic [15:0] flush_asid;
  logic [26:0] flush_vpn;
  logic        upd_v;
  logic [26:0] upd_vpn;
  logic [15:0] upd_asid;
  logic [1:0]  upd_lvl;
  logic [43:0] upd_ppn;
  logic [7:0]  upd_flags;
  logic        lu_v;
  logic [26:0] lu_vpn;
  logic [15:0] lu_asid;
  logic        lu_valid, lu_hit;
  logic [43:0] lu_ppn;
  logic [7:0]  lu_flags;
  logic [1:0]  lu_level;
`ifdef CVA6_TLB_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cva6_l1_tlb_plru dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .flush_asid_en_i (flush_asid_en),
    .flush_vpn_en_i  (flush_vpn_en),
    .flush_asid_i    (flush_asid),
    .flush_vpn_i     (flush_vpn),
    .update_valid_i  (upd_v),
    .update_vpn_i    (upd_vpn),
    .update_asid_i   (upd_asid),
    .update_level_i  (upd_lvl),
    .update_ppn_i    (upd_ppn),
    .update_flags_i  (upd_flags),
    .lu_valid_i      (lu_v),
    .lu_vpn_i        (lu_vpn),
    .lu_asid_i       (lu_asid),
    .lu_valid_o      (lu_valid),
    .lu_hit_o        (lu_hit),
    .lu_ppn_o        (lu_ppn),
    .lu_flags_o      (lu_flags),
    .lu_level_o      (lu_level)
`ifdef CVA6_TLB_PERF_CNT_EN
    ,
    .hit_cnt_o       (hit_cnt),
    .miss_cnt_o      (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic upd(input logic [26:0] vpn, input logic [15:0] asid,
                     input logic [1:0] lvl, input logic [43:0] ppn,
                     input logic [7:0] fl);
    @(negedge clk);
    upd_v = 1'b1; upd_vpn = vpn; upd_asid = asid;
    upd_lvl = lvl; upd_ppn = ppn; upd_flags = fl;
    @(negedge clk);
    upd_v = 1'b0;
  endtask

  task automatic do_flush(input logic ae, input logic ve,
                          input logic [15:0] asid, input logic [26:0] vpn);
    @(negedge clk);
    flush = 1'b1; flush_asid_en = ae; flush_vpn_en = ve;
    flush_asid = asid; flush_vpn = vpn;
    @(negedge clk);
    flush = 1'b0; flush_asid_en = 1'b0; flush_vpn_en = 1'b0;
  endtask

  task automatic look(input string nm, input logic [26:0] vpn,
                      input logic [15:0] asid, input logic eh,
                      input logic [43:0] ep, input logic [1:0] el,
                      input logic [7:0] ef);
    @(negedge clk);
    lu_v = 1'b1; lu_vpn = vpn; lu_asid = asid;
    @(posedge clk);
    #1;
    lu_v = 1'b0;
    check({nm, ".valid"}, 64'(lu_valid), 64'(1'b1));
    check({nm, ".hit"},   64'(lu_hit),   64'(eh));
    check({nm, ".ppn"},   64'(lu_ppn),   64'(ep));
    check({nm, ".level"}, 64'(lu_level), 64'(el));
    check({nm, ".flags"}, 64'(lu_flags), 64'(ef));
  endtask

  typedef struct {
    bit          is_upd;
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [1:0]  lvl;
    logic [43:0] ppn;
    logic [7:0]  fl;
    logic        eh;
    logic [43:0] ep;
    logic [1:0]  el;
    logic [7:0]  ef;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1, 27'h1234,    16'd5, 2'd0, 44'hABC,    8'hCF, 0, 0, 0, 0};
    tbl[1]  = '{0, 27'h1234,    16'd5, 2'd0, 44'h0,      8'h00, 1, 44'hABC, 2'd0, 8'hCF};
    tbl[2]  = '{0, 27'h1234,    16'd6, 2'd0, 44'h0,      8'h00, 0, 0, 0, 0};
    tbl[3]  = '{1, 27'h40000,   16'd5, 2'd1, 44'h800,    8'hC3, 0, 0, 0, 0};
    tbl[4]  = '{0, 27'h40123,   16'd5, 2'd0, 44'h0,      8'h00, 1, 44'h923, 2'd1, 8'hC3};
    tbl[5]  = '{0, 27'h40323,   16'd5, 2'd0, 44'h0,      8'h00, 0, 0, 0, 0};
    tbl[6]  = '{0, 27'h401FF,   16'd5, 2'd0, 44'h0,      8'h00, 1, 44'h9FF, 2'd1, 8'hC3};
    tbl[7]  = '{1, 27'h1234,    16'd5, 2'd0, 44'hDEF,    8'hCF, 0, 0, 0, 0};
    tbl[8]  = '{0, 27'h1234,    16'd5, 2'd0, 44'h0,      8'h00, 1, 44'hDEF, 2'd0, 8'hCF};
    tbl[9]  = '{1, 27'h5555,    16'd9, 2'd0, 44'h111,    8'hE1, 0, 0, 0, 0};
    tbl[10] = '{0, 27'h5555,    16'd2, 2'd0, 44'h0,      8'h00, 1, 44'h111, 2'd0, 8'hE1};
    tbl[11] = '{1, 27'h6000,    16'd5, 2'd0, 44'h222,    8'hCE, 0, 0, 0, 0};
    tbl[12] = '{0, 27'h6000,    16'd5, 2'd0, 44'h0,      8'h00, 0, 0, 0, 0};
    tbl[13] = '{1, 27'h2000000, 16'd5, 2'd2, 44'h100000, 8'hCF, 0, 0, 0, 0};
    tbl[14] = '{0, 27'h2034567, 16'd5, 2'd0, 44'h0,      8'h00, 1, 44'h134567, 2'd2, 8'hCF};
    tbl[15] = '{0, 27'h0,       16'd5, 2'd0, 44'h0,      8'h00, 0, 0, 0, 0};

    rst_n = 1'b0;
    flush = 0; flush_asid_en = 0; flush_vpn_en = 0;
    flush_asid = 0; flush_vpn = 0;
    upd_v = 0; upd_vpn = 0; upd_asid = 0; upd_lvl = 0;
    upd_ppn = 0; upd_flags = 0;
    lu_v = 0; lu_vpn = 0; lu_asid = 0;
    #12;
    check("rst.valid", 64'(lu_valid), 64'd0);
    check("rst.hit",   64'(lu_hit),   64'd0);
    check("rst.ppn",   64'(lu_ppn),   64'd0);
    check("rst.flags", 64'(lu_flags), 64'd0);
    check("rst.level", 64'(lu_level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_upd)
        upd(tbl[i].vpn, tbl[i].asid, tbl[i].lvl, tbl[i].ppn, tbl[i].fl);
      else
        look($sformatf("vec%0d", i), tbl[i].vpn, tbl[i].asid,
             tbl[i].eh, tbl[i].ep, tbl[i].el, tbl[i].ef);
    end

    // Response is a one-cycle pulse; data outputs hold afterwards
    look("pulse", 27'h1234, 16'd5, 1, 44'hDEF, 2'd0, 8'hCF);
    @(posedge clk);
    #1;
    check("pulse.valid_drop", 64'(lu_valid), 64'd0);
    check("pulse.hit_hold",   64'(lu_hit),   64'd1);
    check("pulse.ppn_hold",   64'(lu_ppn),   64'hDEF);

    // Selective flushes by ASID, then by VPN
    do_flush(0, 0, 0, 0);
    look("fl_all", 27'h1234, 16'd5, 0, 0, 0, 0);
    upd(27'h100, 16'd3, 2'd0, 44'hA, 8'hCF);
    upd(27'h200, 16'd3, 2'd0, 44'hB, 8'hEF);
    upd(27'h300, 16'd4, 2'd0, 44'hC, 8'hCF);
    do_flush(1, 0, 16'd3, 0);
    look("asid.A", 27'h100, 16'd3, 0, 0, 0, 0);
    look("asid.B", 27'h200, 16'd3, 1, 44'hB, 2'd0, 8'hEF);
    look("asid.C", 27'h300, 16'd4, 1, 44'hC, 2'd0, 8'hCF);
    do_flush(0, 1, 0, 27'h200);
    look("vpn.B", 27'h200, 16'd3, 0, 0, 0, 0);
    look("vpn.C", 27'h300, 16'd4, 1, 44'hC, 2'd0, 8'hCF);

    // Flush, update and lookup all in the same cycle
    @(negedge clk);
    flush = 1'b1;
    upd_v = 1'b1; upd_vpn = 27'h77; upd_asid = 16'd4;
    upd_lvl = 2'd0; upd_ppn = 44'h777; upd_flags = 8'hCF;
    lu_v = 1'b1; lu_vpn = 27'h300; lu_asid = 16'd4;
    @(posedge clk);
    #1;
    flush = 1'b0; upd_v = 1'b0; lu_v = 1'b0;
    check("same.valid", 64'(lu_valid), 64'd1);
    check("same.miss",  64'(lu_hit),   64'd0);
    check("same.ppn",   64'(lu_ppn),   64'd0);
    look("same.new", 27'h77, 16'd4, 1, 44'h777, 2'd0, 8'hCF);
    look("same.old", 27'h300, 16'd4, 0, 0, 0, 0);

    // Fill, touch 14..0, then the tree points at entry 15
    do_flush(0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      upd(27'h1000 + 27'(i), 16'd1, 2'd0, 44'h100 + 44'(i), 8'hCF);
    for (int i = 14; i >= 0; i--)
      look($sformatf("fill%0d", i), 27'h1000 + 27'(i), 16'd1,
           1, 44'h100 + 44'(i), 2'd0, 8'hCF);
    upd(27'h2000, 16'd1, 2'd0, 44'h999, 8'hCF);
    look("evict.15", 27'h100F, 16'd1, 0, 0, 0, 0);
    look("keep.0",   27'h1000, 16'd1, 1, 44'h100, 2'd0, 8'hCF);
    look("keep.14",  27'h100E, 16'd1, 1, 44'h10E, 2'd0, 8'hCF);
    look("new",      27'h2000, 16'd1, 1, 44'h999, 2'd0, 8'hCF);

    // Reset asserted while a lookup is pending
    @(negedge clk);
    lu_v = 1'b1; lu_vpn = 27'h1000; lu_asid = 16'd1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    lu_v = 1'b0;
    check("rstmid.valid", 64'(lu_valid), 64'd0);
    check("rstmid.hit",   64'(lu_hit),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    look("rstmid.gone", 27'h1000, 16'd1, 0, 0, 0, 0);

`ifdef CVA6_TLB_PERF_CNT_EN
    do_flush(0, 0, 0, 0);
    upd(27'h10, 16'd1, 2'd0, 44'h10, 8'hCF);
    for (int i = 0; i < 3; i++)
      look("cnt.h", 27'h10, 16'd1, 1, 44'h10, 2'd0, 8'hCF);
    for (int i = 0; i < 2; i++)
      look("cnt.m", 27'h11, 16'd1, 0, 0, 0, 0);
    check("cnt.hit",  64'(hit_cnt),  64'd3);
    check("cnt.miss", 64'(miss_cnt), 64'd2);
    do_flush(0, 0, 0, 0);
    check("cnt.hit_clr",  64'(hit_cnt),  64'd0);
    check("cnt.miss_clr", 64'(miss_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
